// File: rtl/div_seq.sv
// div_seq: 32-bit sequential restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define DIV_ZERO_FAST_EN to send a divide-by-zero request straight to DONE with a 1-cycle latency.
module div_seq #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_A,
    input  logic [DATA_W-1:0] i_B,
    input  logic [2:0]        i_func3,
    input  logic              i_kill,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_result,
    output logic              o_busy
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state, state_nxt;
    logic [5:0]          cnt;
    logic                is_rem, sign_a, sign_b, div_zero;
    logic [DATA_W-1:0]   div_b, quo, rem, res;
    logic [DATA_W:0]     shifted, diff;
    logic                accept, op_signed, fast_zero;

    function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] v,
                                                   input logic en);
        return (en && v < 0) ? DATA_W'(-v) : DATA_W'(v);
    endfunction

    function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic en);
        return en ? (~v + DATA_W'(1)) : v;
    endfunction

    assign op_signed = ~i_func3[0];
    // func3 encodings without the top bit set are not divide ops and are never accepted
    assign accept    = (state == IDLE) && i_valid && i_func3[2];
`ifdef DIV_ZERO_FAST_EN
    assign fast_zero = (i_B == '0);
`else
    assign fast_zero = 1'b0;
`endif
    assign o_ready = (state == IDLE);
    assign o_busy  = (state != IDLE);

    // Restoring step: shift in the next dividend bit, try to subtract the divisor
    always_comb begin
        shifted = {rem, quo[DATA_W-1]};
        diff    = shifted - {1'b0, div_b};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = fast_zero ? DONE : CALC;
            CALC: begin
                if (i_kill)                      state_nxt = IDLE;
                else if (cnt == 6'(DATA_W - 1)) state_nxt = FIX;
            end
            FIX:  state_nxt = i_kill ? IDLE : DONE;
            DONE: if (o_valid && i_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept)             cnt <= '0;
            else if (state == CALC) cnt <= cnt + 6'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            is_rem   <= i_func3[1];
            sign_a   <= op_signed && i_A[DATA_W-1];
            sign_b   <= op_signed && i_B[DATA_W-1];
            div_zero <= (i_B == '0);
            quo      <= abs_val(i_A, op_signed);
            div_b    <= abs_val(i_B, op_signed);
            rem      <= '0;
            if (fast_zero) res <= i_func3[1] ? i_A : '1;
        end else if (state == CALC) begin
            quo <= {quo[DATA_W-2:0], ~diff[DATA_W]};
            rem <= diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
        end else if (state == FIX) begin
            // Zero divisor leaves rem = |A|, so the sign fix restores A; quotient is forced
            res <= is_rem   ? neg_if(rem, sign_a) :
                   div_zero ? '1 : neg_if(quo, sign_a ^ sign_b);
        end
    end

    // Result is presented one cycle after entering DONE and cleared on handoff
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid  <= 1'b0;
            o_result <= '0;
        end else if (state == DONE && !o_valid) begin
            o_valid  <= 1'b1;
            o_result <= res;
        end else if (state == DONE && i_ready) begin
            o_valid  <= 1'b0;
            o_result <= '0;
        end
    end

endmodule
